// File: rtl/bcd_code_counter_pkg.sv
// Shared digit-code definitions for the decade counter: code selectors plus
// encode/decode/legality helpers used by every digit and by the load checker.
package bcd_code_pkg;

  localparam int unsigned CODE_8421 = 0;
  localparam int unsigned CODE_2421 = 1;
  localparam int unsigned CODE_XS3  = 2;

  // Decimal 0..9 to its nibble in the selected code.
  function automatic logic [3:0] enc(input logic [3:0] val, input int unsigned code);
    logic [3:0] r;
    case (code)
      CODE_2421: r = (val < 4'd5) ? val : val + 4'd6;
      CODE_XS3:  r = val + 4'd3;
      default:   r = val;
    endcase
    return r;
  endfunction

  // Nibble back to decimal; only meaningful for legal nibbles.
  function automatic logic [3:0] dec(input logic [3:0] nib, input int unsigned code);
    logic [3:0] r;
    case (code)
      CODE_2421: r = (nib < 4'd5) ? nib : nib - 4'd6;
      CODE_XS3:  r = nib - 4'd3;
      default:   r = nib;
    endcase
    return r;
  endfunction

  function automatic logic is_legal(input logic [3:0] nib, input int unsigned code);
    logic r;
    case (code)
      CODE_2421: r = (nib <= 4'd4) || (nib >= 4'd11);
      CODE_XS3:  r = (nib >= 4'd3) && (nib <= 4'd12);
      default:   r = (nib <= 4'd9);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_code_counter_if.sv
// Control/data bundle of the decade counter; the master drives controls and
// load data, the counter (slave) returns count, terminal count and error.
interface bcd_code_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  err;

  modport master (
    output en, up, clear, load, load_val,
    input  count, tc, err
  );

  modport slave (
    input  en, up, clear, load, load_val,
    output count, tc, err
  );
endinterface

// File: rtl/bcd_code_counter_digit.sv
// One decade of the counter: holds a nibble in the chosen code, steps up or
// down with wrap, loads with legality scrubbing and recovers illegal state.
module bcd_code_digit
  import bcd_code_pkg::*;
#(
  parameter int unsigned CODE = CODE_2421
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic       clear,
  input  logic [3:0] ld_nib,
  output logic [3:0] nib,
  output logic       at_max,
  output logic       at_min,
  output logic       illegal
);

  localparam logic [3:0] ZERO = enc(4'd0, CODE);
  localparam logic [3:0] NINE = enc(4'd9, CODE);

  logic [3:0] r_nib;
  logic [3:0] w_next;
  logic [3:0] w_val;

  assign nib     = r_nib;
  assign illegal = ~is_legal(r_nib, CODE);
  assign at_max  = (r_nib == NINE);
  assign at_min  = (r_nib == ZERO);

  always_comb begin
    w_val  = dec(r_nib, CODE);
    w_next = r_nib;
    if (clear) begin
      w_next = ZERO;
    end else if (load) begin
      w_next = is_legal(ld_nib, CODE) ? ld_nib : ZERO;
    end else if (step) begin
      // An illegal held code is scrubbed to zero instead of stepped.
      if (illegal)
        w_next = ZERO;
      else if (up)
        w_next = at_max ? ZERO : enc(w_val + 4'd1, CODE);
      else
        w_next = at_min ? NINE : enc(w_val - 4'd1, CODE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_nib <= ZERO;
    else
      r_nib <= w_next;
  end

endmodule

// File: rtl/bcd_code_counter.sv
// Multi-digit decimal up/down counter with selectable digit code, cascadable
// terminal count and a sticky illegal-code flag.
module bcd_code_counter
  import bcd_code_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CODE   = CODE_2421
) (
  input  logic              clk,
  input  logic              rst,
  bcd_code_counter_if.slave bus
);

  logic [DIGITS-1:0]   w_at_max;
  logic [DIGITS-1:0]   w_at_min;
  logic [DIGITS-1:0]   w_illegal;
  logic [DIGITS-1:0]   w_step;
  logic [DIGITS-1:0]   w_ld_bad;
  logic [DIGITS-1:0]   w_carry;
  logic [4*DIGITS-1:0] w_count;
  logic                r_err;

  // Digit i steps when all lower digits sit at the boundary for this direction;
  // illegal digits never sit at a boundary, so they break the chain.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = 1'b1;
    for (int unsigned i = 1; i < DIGITS; i++)
      w_carry[i] = w_carry[i-1] & (bus.up ? w_at_max[i-1] : w_at_min[i-1]);
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign w_step[gi]   = bus.en & (w_carry[gi] | w_illegal[gi]);
    assign w_ld_bad[gi] = ~is_legal(bus.load_val[4*gi +: 4], CODE);

    bcd_code_digit #(
      .CODE (CODE)
    ) u_digit (
      .clk     (clk),
      .rst     (rst),
      .step    (w_step[gi]),
      .up      (bus.up),
      .load    (bus.load),
      .clear   (bus.clear),
      .ld_nib  (bus.load_val[4*gi +: 4]),
      .nib     (w_count[4*gi +: 4]),
      .at_max  (w_at_max[gi]),
      .at_min  (w_at_min[gi]),
      .illegal (w_illegal[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (bus.clear)
      r_err <= 1'b0;
    else if (bus.load) begin
      if (|w_ld_bad)
        r_err <= 1'b1;
    end else if (bus.en && (|w_illegal))
      r_err <= 1'b1;
  end

  assign bus.count = w_count;
  assign bus.err   = r_err;
  assign bus.tc    = bus.en & (bus.up ? (&w_at_max) : (&w_at_min));

endmodule
